// File: rtl/sd_sched_pkg.sv
// Shared types and frame-geometry constants for the SD-card frame write scheduler.
package sd_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_DATA = 3'd2,
    ISSUE     = 3'd3,
    WAIT_HI   = 3'd4,
    WAIT_LO   = 3'd5,
    NEXT      = 3'd6
  } sched_state_e;

  localparam int SECTOR_BYTES    = 512;
  localparam int FRAME_WIDTH     = 1280;
  localparam int FRAME_HEIGHT    = 800;
  localparam int BYTES_PER_PIXEL = 2;   // RGB565
  localparam int FRAME_BYTES     = FRAME_WIDTH * FRAME_HEIGHT * BYTES_PER_PIXEL;
  localparam int FRAME_SECTORS   = FRAME_BYTES / SECTOR_BYTES;
  localparam int SECTOR_WORD_CNT = SECTOR_BYTES / 2;

endpackage

// File: rtl/sd_sect_addr_gen.sv
// Frame slot and sector counters plus the slot base-address accumulator that
// produce the sector address handed to sd_ctrl.
module sd_sect_addr_gen
  import sd_sched_pkg::*;
#(
  parameter int          SECTORS_PER_FRAME = FRAME_SECTORS,
  parameter logic [31:0] START_SECTOR      = 32'd16000,
  parameter int          MAX_FRAMES        = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        clr_cnt,
  input  logic        load_addr,
  input  logic        sect_inc,
  output logic [31:0] wr_addr,
  output logic [2:0]  frame_idx,
  output logic [11:0] sect_cnt,
  output logic        last_sect
);

  logic [31:0] base_r;
  logic [31:0] wr_addr_r;
  logic [2:0]  frame_idx_r;
  logic [11:0] sect_cnt_r;
  logic        last_sect_s;

  assign last_sect_s = (sect_cnt_r == 12'(SECTORS_PER_FRAME - 1));

  // Counters, slot base (incremental add instead of a multiplier) and address register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      base_r      <= START_SECTOR;
      wr_addr_r   <= START_SECTOR;
      frame_idx_r <= 3'd0;
      sect_cnt_r  <= 12'd0;
    end else begin
      if (clr_cnt) begin
        sect_cnt_r <= 12'd0;
      end else if (sect_inc) begin
        sect_cnt_r <= sect_cnt_r + 12'd1;
      end
      if (load_addr) begin
        wr_addr_r <= base_r + {20'd0, sect_cnt_r};
      end
      if (sect_inc && last_sect_s) begin
        if (frame_idx_r == 3'(MAX_FRAMES - 1)) begin
          frame_idx_r <= 3'd0;
          base_r      <= START_SECTOR;
        end else begin
          frame_idx_r <= frame_idx_r + 3'd1;
          base_r      <= base_r + 32'(SECTORS_PER_FRAME);
        end
      end
    end
  end

  assign wr_addr   = wr_addr_r;
  assign frame_idx = frame_idx_r;
  assign sect_cnt  = sect_cnt_r;
  assign last_sect = last_sect_s;

endmodule

// File: rtl/sd_frame_wr_sched.sv
// Sequences whole-frame dumps from the SD write FIFO into sd_ctrl one sector at
// a time, with busy-handshake tracking and a sticky timeout error.
module sd_frame_wr_sched
  import sd_sched_pkg::*;
#(
  parameter int          SECTOR_WORDS      = SECTOR_WORD_CNT,
  parameter int          SECTORS_PER_FRAME = FRAME_SECTORS,
  parameter logic [31:0] START_SECTOR      = 32'd16000,
  parameter int          MAX_FRAMES        = 8,
  parameter int          BUSY_TMO          = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        capture_req,
  input  logic        frame_start,
  input  logic        init_end,
  input  logic [11:0] fifo_usedw,
  input  logic        wr_busy,
  output logic        fifo_clr,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic        sched_busy,
  output logic        frame_done,
  output logic [2:0]  frame_idx,
  output logic [11:0] sect_cnt,
  output logic        err
);

  localparam int TMO_W = $clog2(BUSY_TMO + 1);

  sched_state_e     state_r, state_nxt_s;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             fifo_clr_r, wr_en_r, sched_busy_r, frame_done_r, err_r;
  logic             arm_s, tmo_hit_s, last_sect_s;

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    arm_s       = 1'b0;
    tmo_hit_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (capture_req && init_end) begin
          state_nxt_s = ARM;
          arm_s       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      // frame_start coinciding with the clear pulse belongs to the old FIFO contents
      ARM: begin
        if (frame_start && !fifo_clr_r) begin
          state_nxt_s = WAIT_DATA;
        end else begin
          state_nxt_s = ARM;
        end
      end
      WAIT_DATA: begin
        if (fifo_usedw >= 12'(SECTOR_WORDS)) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = WAIT_DATA;
        end
      end
      ISSUE: state_nxt_s = WAIT_HI;
      WAIT_HI: begin
        if (wr_busy) begin
          state_nxt_s = WAIT_LO;
        end else if (tmo_cnt_r == TMO_W'(BUSY_TMO - 1)) begin
          state_nxt_s = IDLE;
          tmo_hit_s   = 1'b1;
        end else begin
          state_nxt_s = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (!wr_busy) begin
          state_nxt_s = NEXT;
        end else begin
          state_nxt_s = WAIT_LO;
        end
      end
      NEXT: begin
        if (last_sect_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_DATA;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register, busy timeout counter and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r      <= IDLE;
      tmo_cnt_r    <= {TMO_W{1'b0}};
      fifo_clr_r   <= 1'b0;
      wr_en_r      <= 1'b0;
      sched_busy_r <= 1'b0;
      frame_done_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      tmo_cnt_r    <= (state_r == WAIT_HI) ? tmo_cnt_r + TMO_W'(1'b1) : {TMO_W{1'b0}};
      fifo_clr_r   <= arm_s;
      wr_en_r      <= (state_r == ISSUE);
      sched_busy_r <= (state_nxt_s != IDLE);
      frame_done_r <= (state_r == NEXT) && last_sect_s;
      if (arm_s) begin
        err_r <= 1'b0;
      end else if (tmo_hit_s) begin
        err_r <= 1'b1;
      end
    end
  end

  sd_sect_addr_gen #(
    .SECTORS_PER_FRAME (SECTORS_PER_FRAME),
    .START_SECTOR      (START_SECTOR),
    .MAX_FRAMES        (MAX_FRAMES)
  ) u_addr_gen (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .clr_cnt   (arm_s),
    .load_addr (state_r == ISSUE),
    .sect_inc  (state_r == NEXT),
    .wr_addr   (wr_addr),
    .frame_idx (frame_idx),
    .sect_cnt  (sect_cnt),
    .last_sect (last_sect_s)
  );

  assign fifo_clr   = fifo_clr_r;
  assign wr_en      = wr_en_r;
  assign sched_busy = sched_busy_r;
  assign frame_done = frame_done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_sd_frame_wr_sched.sv
// Directed bench: cycle vector table for arming/latency, then sequences for a full
// frame, slot wrap (4-sector instance), busy timeout, threshold wait and reset.
module tb_sd_frame_wr_sched;

  logic        sys_clk = 1'b0;
  logic        sys_rst, cap_a, cap_b, frame_start, init_end;
  logic [11:0] fifo_usedw;
  logic        wr_busy = 1'b0;
  logic        fifo_clr_a, wr_en_a, sched_busy_a, frame_done_a, err_a;
  logic        fifo_clr_b, wr_en_b, sched_busy_b, frame_done_b, err_b;
  logic [31:0] wr_addr_a, wr_addr_b;
  logic [2:0]  frame_idx_a, frame_idx_b;
  logic [11:0] sect_cnt_a, sect_cnt_b;

  always #10 sys_clk = ~sys_clk;

  sd_frame_wr_sched dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .capture_req(cap_a), .frame_start(frame_start),
    .init_end(init_end), .fifo_usedw(fifo_usedw), .wr_busy(wr_busy), .fifo_clr(fifo_clr_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .sched_busy(sched_busy_a), .frame_done(frame_done_a),
    .frame_idx(frame_idx_a), .sect_cnt(sect_cnt_a), .err(err_a));

  sd_frame_wr_sched #(.SECTORS_PER_FRAME(4)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .capture_req(cap_b), .frame_start(frame_start),
    .init_end(init_end), .fifo_usedw(fifo_usedw), .wr_busy(wr_busy), .fifo_clr(fifo_clr_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .sched_busy(sched_busy_b), .frame_done(frame_done_b),
    .frame_idx(frame_idx_b), .sect_cnt(sect_cnt_b), .err(err_b));

  // sd_ctrl model: busy rises 2 cycles after wr_en, stays high busy_len cycles
  int   sd_mode = 0, busy_len = 100, sd_left = 0;
  logic sd_ph = 1'b0;
  always @(posedge sys_clk) begin
    if (sd_ph) begin
      wr_busy <= 1'b1;
      sd_left <= busy_len;
    end else if (wr_busy) begin
      if (sd_left <= 1) wr_busy <= 1'b0;
      else sd_left <= sd_left - 1;
    end
    sd_ph <= (wr_en_a || wr_en_b) && (sd_mode == 0);
  end

  int cyc = 0, n_clr_a = 0, n_fd_a = 0, n_clr_b = 0, n_fd_b = 0;
  logic [31:0] q_a[$], q_b[$];
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(negedge sys_clk) begin
    if (fifo_clr_a) n_clr_a <= n_clr_a + 1;
    if (frame_done_a) n_fd_a <= n_fd_a + 1;
    if (wr_en_a) q_a.push_back(wr_addr_a);
    if (fifo_clr_b) n_clr_b <= n_clr_b + 1;
    if (frame_done_b) n_fd_b <= n_fd_b + 1;
    if (wr_en_b) q_b.push_back(wr_addr_b);
  end

  int checks = 0, errors = 0;
  task automatic check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        cap;
    logic        fs;
    logic        init;
    logic [11:0] usedw;
    logic        clr;
    logic        wen;
    logic        busy;
    logic [31:0] addr;
  } vec_t;

  function automatic vec_t mk(input logic cap, input logic fs, input logic init,
                              input logic [11:0] usedw, input logic clr, input logic wen,
                              input logic busy, input logic [31:0] addr);
    vec_t v;
    v.cap = cap; v.fs = fs; v.init = init; v.usedw = usedw;
    v.clr = clr; v.wen = wen; v.busy = busy; v.addr = addr;
    return v;
  endfunction

  vec_t vecs [12];

  initial begin
    int n, qb, bad, b_clr, b_fd, t0;
    //             cap   fs    init  usedw    clr   wen   busy  addr
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 12'd0,   1'b0, 1'b0, 1'b0, 32'd16000); // reset state
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 12'd0,   1'b0, 1'b0, 1'b0, 32'd16000); // dropped: init_end=0
    vecs[2]  = mk(1'b0, 1'b0, 1'b1, 12'd0,   1'b0, 1'b0, 1'b0, 32'd16000);
    vecs[3]  = mk(1'b1, 1'b0, 1'b1, 12'd0,   1'b1, 1'b0, 1'b1, 32'd16000); // accepted -> clr
    vecs[4]  = mk(1'b0, 1'b1, 1'b1, 12'd256, 1'b0, 1'b0, 1'b1, 32'd16000); // fs in clr cycle
    vecs[5]  = mk(1'b1, 1'b0, 1'b1, 12'd256, 1'b0, 1'b0, 1'b1, 32'd16000); // cap ignored
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 12'd256, 1'b0, 1'b0, 1'b1, 32'd16000); // still ARM
    vecs[7]  = mk(1'b0, 1'b1, 1'b1, 12'd255, 1'b0, 1'b0, 1'b1, 32'd16000); // -> WAIT_DATA
    vecs[8]  = mk(1'b0, 1'b1, 1'b1, 12'd255, 1'b0, 1'b0, 1'b1, 32'd16000);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 12'd256, 1'b0, 1'b0, 1'b1, 32'd16000); // -> ISSUE
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 12'd256, 1'b0, 1'b1, 1'b1, 32'd16000); // wr_en
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 12'd0,   1'b0, 1'b0, 1'b1, 32'd16000);

    sys_rst = 1'b1; cap_a = 1'b0; cap_b = 1'b0; frame_start = 1'b0;
    init_end = 1'b0; fifo_usedw = 12'd0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      cap_a = vecs[i].cap; frame_start = vecs[i].fs;
      init_end = vecs[i].init; fifo_usedw = vecs[i].usedw;
      @(negedge sys_clk);
      check_eq($sformatf("vec%0d.fifo_clr", i), fifo_clr_a, vecs[i].clr);
      check_eq($sformatf("vec%0d.wr_en", i), wr_en_a, vecs[i].wen);
      check_eq($sformatf("vec%0d.sched_busy", i), sched_busy_a, vecs[i].busy);
      check_eq($sformatf("vec%0d.wr_addr", i), wr_addr_a, vecs[i].addr);
      check_eq($sformatf("vec%0d.frame_done", i), frame_done_a, 0);
      check_eq($sformatf("vec%0d.err", i), err_a, 0);
      check_eq($sformatf("vec%0d.sect_cnt", i), sect_cnt_a, 0);
      check_eq($sformatf("vec%0d.frame_idx", i), frame_idx_a, 0);
    end
    cap_a = 1'b0; frame_start = 1'b0; fifo_usedw = 12'd0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);
    n = 0;
    while (wr_busy && n < 500) begin @(negedge sys_clk); n++; end
    check_eq("settle_after_table", n < 500, 1);

    // Full 4000-sector frame; short sd busy time keeps the run bounded
    busy_len = 5;
    b_clr = n_clr_a; b_fd = n_fd_a; qb = q_a.size();
    cap_a = 1'b1; @(negedge sys_clk); cap_a = 1'b0;
    repeat (9) @(negedge sys_clk);
    frame_start = 1'b1; @(negedge sys_clk); frame_start = 1'b0;
    fifo_usedw = 12'd256;
    n = 0;
    while (!frame_done_a && n < 60000) begin @(negedge sys_clk); n++; end
    check_eq("t1_frame_done_seen", n < 60000, 1);
    repeat (2) @(negedge sys_clk);
    fifo_usedw = 12'd0;
    check_eq("t1_fifo_clr_count", n_clr_a - b_clr, 1);
    check_eq("t1_wr_en_count", q_a.size() - qb, 4000);
    bad = 0;
    for (int i = 0; i < 4000 && qb + i < q_a.size(); i++)
      if (q_a[qb + i] != 32'(16000 + i)) bad++;
    check_eq("t1_addr_seq_bad", bad, 0);
    check_eq("t1_frame_done_count", n_fd_a - b_fd, 1);
    check_eq("t1_frame_idx", frame_idx_a, 1);
    check_eq("t1_sect_cnt", sect_cnt_a, 4000);
    check_eq("t1_sched_busy", sched_busy_a, 0);

    // Nine back-to-back 4-sector frames on dut_b: slot wrap, ignored pulses mid-frame
    busy_len = 100;
    b_clr = n_clr_b; b_fd = n_fd_b; qb = q_b.size();
    for (int f = 0; f < 9; f++) begin
      check_eq($sformatf("t2_idx_before_f%0d", f), frame_idx_b, f % 8);
      cap_b = 1'b1; @(negedge sys_clk); cap_b = 1'b0;
      repeat (2) @(negedge sys_clk);
      frame_start = 1'b1; @(negedge sys_clk); frame_start = 1'b0;
      fifo_usedw = 12'd256;
      if (f == 0) begin
        repeat (150) @(negedge sys_clk);
        cap_b = 1'b1; frame_start = 1'b1;
        @(negedge sys_clk);
        cap_b = 1'b0; frame_start = 1'b0;
      end
      n = 0;
      while (!frame_done_b && n < 2000) begin @(negedge sys_clk); n++; end
      check_eq($sformatf("t2_done_seen_f%0d", f), n < 2000, 1);
      fifo_usedw = 12'd0;
      @(negedge sys_clk);
      if (f == 7) check_eq("t2_idx_wrap_7_to_0", frame_idx_b, 0);
    end
    repeat (2) @(negedge sys_clk);
    check_eq("t2_wr_en_count", q_b.size() - qb, 36);
    check_eq("t2_fifo_clr_count", n_clr_b - b_clr, 9);
    check_eq("t2_frame_done_count", n_fd_b - b_fd, 9);
    check_eq("t2_frame_idx_end", frame_idx_b, 1);
    bad = 0;
    for (int i = 0; i < 36 && qb + i < q_b.size(); i++)
      if (q_b[qb + i] != 32'(16000 + ((i / 4) % 8) * 4 + (i % 4))) bad++;
    check_eq("t2_addr_seq_bad", bad, 0);
    for (int s = 0; s < 4; s++)
      if (qb + 32 + s < q_b.size())
        check_eq($sformatf("t2_frame8_addr%0d", s), q_b[qb + 32 + s], 16000 + s);

    // Busy timeout on the third sector of frame slot 1
    busy_len = 5; sd_mode = 0;
    cap_a = 1'b1; @(negedge sys_clk); cap_a = 1'b0;
    repeat (2) @(negedge sys_clk);
    frame_start = 1'b1; @(negedge sys_clk); frame_start = 1'b0;
    fifo_usedw = 12'd256;
    n = 0;
    while (sect_cnt_a != 12'd2 && n < 500) begin @(negedge sys_clk); n++; end
    check_eq("t3_two_sectors", n < 500, 1);
    sd_mode = 1;
    n = 0;
    while (!wr_en_a && n < 50) begin @(negedge sys_clk); n++; end
    check_eq("t3_third_wr_en", n < 50, 1);
    t0 = cyc;
    check_eq("t3_third_addr", wr_addr_a, 20002);
    n = 0;
    while (!err_a && n < 2000) begin @(negedge sys_clk); n++; end
    check_eq("t3_err_latency", cyc - t0, 1024);
    check_eq("t3_sched_busy", sched_busy_a, 0);
    check_eq("t3_frame_idx", frame_idx_a, 1);
    qb = q_a.size();
    repeat (5) @(negedge sys_clk);
    check_eq("t3_sect_cnt_frozen", sect_cnt_a, 2);
    check_eq("t3_err_sticky", err_a, 1);
    check_eq("t3_no_reissue", q_a.size() - qb, 0);
    sd_mode = 0; busy_len = 100;
    cap_a = 1'b1; @(negedge sys_clk); cap_a = 1'b0;
    check_eq("t3_err_cleared", err_a, 0);
    check_eq("t3_rearm_clr", fifo_clr_a, 1);
    check_eq("t3_rearm_sect_cnt", sect_cnt_a, 0);

    // Threshold: 255 must not trigger; 256 gives wr_en two edges later
    fifo_usedw = 12'd0;
    @(negedge sys_clk);
    frame_start = 1'b1; @(negedge sys_clk); frame_start = 1'b0;
    fifo_usedw = 12'd255;
    qb = q_a.size();
    repeat (50) @(negedge sys_clk);
    check_eq("t5_no_wr_en_at_255", q_a.size() - qb, 0);
    fifo_usedw = 12'd256;
    @(negedge sys_clk);
    check_eq("t5_wr_en_edge1", wr_en_a, 0);
    @(negedge sys_clk);
    check_eq("t5_wr_en_edge2", wr_en_a, 1);
    check_eq("t5_wr_addr", wr_addr_a, 20000);

    // Reset while in WAIT_LO at sect_cnt 7
    n = 0;
    while (!(sect_cnt_a == 12'd7 && wr_busy) && n < 3000) begin @(negedge sys_clk); n++; end
    check_eq("t6_reach_sect7_busy", n < 3000, 1);
    @(negedge sys_clk);
    qb = q_a.size();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check_eq("t6_wr_en", wr_en_a, 0);
    check_eq("t6_fifo_clr", fifo_clr_a, 0);
    check_eq("t6_sched_busy", sched_busy_a, 0);
    check_eq("t6_frame_done", frame_done_a, 0);
    check_eq("t6_err", err_a, 0);
    check_eq("t6_wr_addr", wr_addr_a, 16000);
    check_eq("t6_frame_idx", frame_idx_a, 0);
    check_eq("t6_sect_cnt", sect_cnt_a, 0);
    repeat (300) @(negedge sys_clk);
    check_eq("t6_no_wr_en_after_reset", q_a.size() - qb, 0);
    check_eq("t6_still_idle", sched_busy_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_frame_wr_sched.md
Name: sd_frame_wr_sched

Overview:
- Sequencer between the SD-card write FIFO and the SD controller (sd_ctrl) for dumping whole camera frames to the card, sector by sector.
- On a capture request, it arms on the next frame start and clears the SD write FIFO.
- For each sector it waits for one sector of data, pulses the SD write enable and tracks the controller's busy handshake.
- It steps the sector address through a ring of frame slots, and reports completion, progress and errors.

Parameters:
- SECTOR_WORDS, 256: 16-bit words per 512-byte sector; FIFO level that triggers a sector write.
- SECTORS_PER_FRAME, 4000: sectors per frame (1280x800x2 B / 512).
- START_SECTOR, 32'd16000: first card sector of frame slot 0.
- MAX_FRAMES, 8: number of frame slots before the slot index wraps to 0.
- BUSY_TMO, 1024: maximum clocks from wr_en to wr_busy rising.

Ports:
- sys_clk, in, 1: 50 MHz clock; FIFO read side and sd_ctrl use the same clock.
- sys_rst, in, 1: synchronous reset, active-high.
- capture_req, in, 1: one-cycle request to store one frame.
- frame_start, in, 1: one-cycle pulse at the start of a video frame (vsync edge, already synchronised).
- init_end, in, 1: SD card initialisation complete.
- fifo_usedw, in, 12: SD write FIFO read-side fill level.
- wr_busy, in, 1: sd_ctrl write in progress.
- fifo_clr, out, 1: one-cycle FIFO clear.
- wr_en, out, 1: one-cycle sector write start to sd_ctrl.
- wr_addr, out, 32: sector address; held stable from wr_en until wr_busy falls.
- sched_busy, out, 1: high in every state except IDLE.
- frame_done, out, 1: one-cycle pulse when the last sector of a frame completes.
- frame_idx, out, 3: current slot index, 0..MAX_FRAMES-1.
- sect_cnt, out, 12: sectors completed in the current frame.
- err, out, 1: sticky busy-timeout flag; cleared by the next accepted capture_req.

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - State goes to IDLE.
  - wr_en, fifo_clr, frame_done, err and sched_busy all 0.
  - wr_addr = START_SECTOR; frame_idx = 0; sect_cnt = 0.
  - Reset mid-write aborts immediately with no wr_en re-issue; sd_ctrl finishes its own transfer.
- IDLE: capture_req=1 with init_end=1 -> ARM. Capture_req while init_end=0 is dropped.
- ARM:
  - The cycle after entry: fifo_clr=1 for one cycle, err cleared, sect_cnt=0.
  - Wait for frame_start, then go to WAIT_DATA.
  - A frame_start in the same cycle as the fifo_clr pulse is not taken; only a later frame_start counts.
- WAIT_DATA: fifo_usedw >= SECTOR_WORDS -> ISSUE.
- ISSUE:
  - wr_en=1 for exactly one cycle.
  - wr_addr = START_SECTOR + frame_idx*SECTORS_PER_FRAME + sect_cnt, registered so it is valid in the wr_en cycle.
  - Next state WAIT_HI.
- WAIT_HI:
  - wr_busy=1 -> WAIT_LO.
  - A timeout counter counts from the wr_en cycle. On reaching BUSY_TMO without wr_busy: err=1, frame abandoned, go to IDLE, frame_idx unchanged.
- WAIT_LO: wr_busy=0 -> NEXT.
- NEXT: sect_cnt increments.
  - If the new value equals SECTORS_PER_FRAME: frame_done=1 for one cycle; frame_idx increments, wrapping from MAX_FRAMES-1 to 0; go to IDLE.
  - Otherwise go to WAIT_DATA.
- Latency:
  - wr_en is asserted 2 cycles after the edge at which fifo_usedw first reaches the threshold: one cycle to register into ISSUE, one to drive output.
  - Sector-to-sector overhead is 3 cycles beyond sd_ctrl busy time.
- Ignored inputs:
  - capture_req outside IDLE is ignored, with no queuing.
  - frame_start outside ARM is ignored.
- Address arithmetic:
  - Performed in 32 bits.
  - The constant product frame_idx*SECTORS_PER_FRAME comes from a MAX_FRAMES-entry lookup or an incremental add; no runtime multiplier.
  - Overflow beyond 2^32 is not checked; parameters guarantee it.
- init_end dropping mid-frame has no effect; sd_ctrl owns the card state.

Decomposition:
- Shared package sd_sched_pkg holds:
  - the state enum (IDLE, ARM, WAIT_DATA, ISSUE, WAIT_HI, WAIT_LO, NEXT);
  - SECTOR_BYTES = 512;
  - the frame-size constants derived from the 1280x800 RGB565 format.
- One natural sub-module, sd_sect_addr_gen: slot and sector counters plus the base-address accumulator, producing wr_addr, frame_idx and sect_cnt.
- The FSM and timeout counter stay in the top module.

Test Plan:
1. Reset, init_end=1, capture_req, then frame_start 10 cycles later; fifo model raises usedw to 256 and sd model answers wr_busy high 2 cycles after wr_en, low 100 cycles later. Required: fifo_clr once; 4000 wr_en pulses; wr_addr runs 16000..19999; one frame_done; frame_idx=1; sched_busy low at the end.
2. Nine back-to-back captures with SECTORS_PER_FRAME overridden to 4. Required: frame 8 writes at 16000..16003; frame_idx goes 7 -> 0.
3. sd model never raises wr_busy. Required: err=1 exactly BUSY_TMO cycles after wr_en; state IDLE; sect_cnt frozen; the next capture_req clears err.
4. capture_req with init_end=0. Required: no fifo_clr and sched_busy stays 0. Also: capture_req and frame_start pulses during a frame must not change wr_addr sequence or counts.
5. fifo_usedw held at 255 for 50 cycles, then 256. Required: no wr_en until 256 is reached; wr_en 2 cycles after it.
6. sys_rst asserted while in WAIT_LO at sect_cnt=7. Required: next cycle all outputs at reset values, wr_addr=16000, no further wr_en.
